// File: rtl/cnn_conv_stream.sv
// Streaming 3x3 convolution over a raster pixel stream, NUM_CH output channels.
// Two line buffers feed a sliding window; each channel does MAC, ReLU, shift and saturate.
module cnn_conv_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int IMG_W_MAX  = 32,
    parameter int IMG_H_MAX  = 32,
    parameter int NUM_CH     = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               start_i,
    input  logic [$clog2(IMG_W_MAX+1)-1:0]     img_w_i,
    input  logic [$clog2(IMG_H_MAX+1)-1:0]     img_h_i,
    input  logic                               relu_en_i,
    input  logic [$clog2(ACC_WIDTH)-1:0]       shift_i,
    input  logic                               wt_we_i,
    input  logic [$clog2(NUM_CH*9)-1:0]        wt_addr_i,
    input  logic [DATA_WIDTH-1:0]              wt_wdata_i,
    input  logic                               pix_valid_i,
    output logic                               pix_ready_o,
    input  logic [DATA_WIDTH-1:0]              pix_data_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [NUM_CH*DATA_WIDTH-1:0]       out_data_o,
    output logic                               out_last_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               err_o
);
    localparam int WW = $clog2(IMG_W_MAX+1);
    localparam int HW = $clog2(IMG_H_MAX+1);
    localparam int SW = $clog2(ACC_WIDTH);
    localparam int LW = (IMG_W_MAX > 1) ? $clog2(IMG_W_MAX) : 1;
    localparam int NW = NUM_CH*9;
    localparam int EW = ACC_WIDTH - DATA_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                      state_q;
    logic                        err_q;
    logic [WW-1:0]               w_q, w_d, col_q, col_d;
    logic [HW-1:0]               h_q, h_d, row_q, row_d;
    logic                        relu_q, relu_d;
    logic [SW-1:0]               shift_q, shift_d;
    logic [DATA_WIDTH-1:0]       wt_q [NW];
    logic [DATA_WIDTH-1:0]       wt_d [NW];
    logic [DATA_WIDTH-1:0]       lb0_q [IMG_W_MAX];
    logic [DATA_WIDTH-1:0]       lb0_d [IMG_W_MAX];
    logic [DATA_WIDTH-1:0]       lb1_q [IMG_W_MAX];
    logic [DATA_WIDTH-1:0]       lb1_d [IMG_W_MAX];
    logic [DATA_WIDTH-1:0]       win_q [9];
    logic [DATA_WIDTH-1:0]       win_d [9];
    logic [DATA_WIDTH-1:0]       tap   [9];
    logic                        out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [NUM_CH*DATA_WIDTH-1:0] out_data_q, out_data_d, res;
    logic signed [ACC_WIDTH-1:0] acc;

    logic          dims_bad, start_go, pix_fire, out_fire, last_pix, has_win;
    logic [LW-1:0] col_idx;

    assign dims_bad = (img_w_i < WW'(3)) || (img_h_i < HW'(3)) ||
                      (img_w_i > WW'(IMG_W_MAX)) || (img_h_i > HW'(IMG_H_MAX));
    assign start_go    = (state_q == IDLE) && start_i;
    assign pix_ready_o = (state_q == RUN) && (!out_valid_q || out_ready_i);
    assign pix_fire    = pix_valid_i && pix_ready_o;
    assign out_fire    = out_valid_q && out_ready_i;
    assign last_pix    = (row_q == h_q - HW'(1)) && (col_q == w_q - WW'(1));
    assign has_win     = (row_q >= HW'(2)) && (col_q >= WW'(2));
    assign col_idx     = col_q[LW-1:0];

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign err_o       = err_q;

    // Window as it will look once the incoming pixel is shifted in: rows top..bottom.
    always_comb begin
        for (int m = 0; m < 3; m++) begin
            tap[m*3]   = win_q[m*3+1];
            tap[m*3+1] = win_q[m*3+2];
        end
        tap[2] = lb0_q[col_idx];
        tap[5] = lb1_q[col_idx];
        tap[8] = pix_data_i;
    end

    always_comb begin
        res = '0;
        acc = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            acc = '0;
            for (int k = 0; k < 9; k++) begin
                acc = acc + $signed({{EW{1'b0}}, tap[k]}) *
                            $signed({{EW{wt_q[ch*9+k][DATA_WIDTH-1]}}, wt_q[ch*9+k]});
            end
            if (relu_q && (acc < 0)) acc = '0;
            acc = acc >>> shift_q;
            if (acc > SAT_MAX)      res[ch*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
            else if (acc < SAT_MIN) res[ch*DATA_WIDTH +: DATA_WIDTH] = SAT_MIN[DATA_WIDTH-1:0];
            else                    res[ch*DATA_WIDTH +: DATA_WIDTH] = acc[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        w_d = w_q; h_d = h_q; relu_d = relu_q; shift_d = shift_q;
        col_d = col_q; row_d = row_q;
        wt_d = wt_q; lb0_d = lb0_q; lb1_d = lb1_q; win_d = win_q;
        out_valid_d = out_valid_q; out_last_d = out_last_q; out_data_d = out_data_q;

        if (start_go && !dims_bad) begin
            w_d = img_w_i; h_d = img_h_i; relu_d = relu_en_i; shift_d = shift_i;
            col_d = '0; row_d = '0;
        end
        if ((state_q == IDLE) && wt_we_i && (32'(wt_addr_i) < NW))
            wt_d[wt_addr_i] = wt_wdata_i;

        if (out_fire) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (pix_fire) begin
            lb0_d[col_idx] = lb1_q[col_idx];
            lb1_d[col_idx] = pix_data_i;
            for (int k = 0; k < 9; k++) win_d[k] = tap[k];
            if (col_q == w_q - WW'(1)) begin
                col_d = '0;
                row_d = row_q + HW'(1);
            end else begin
                col_d = col_q + WW'(1);
            end
            if (has_win) begin
                out_valid_d = 1'b1;
                out_data_d  = res;
                out_last_d  = last_pix;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            w_q <= '0; h_q <= '0; relu_q <= 1'b0; shift_q <= '0;
            col_q <= '0; row_q <= '0;
            out_valid_q <= 1'b0; out_last_q <= 1'b0; out_data_q <= '0;
            for (int i = 0; i < NW; i++) wt_q[i] <= '0;
            for (int i = 0; i < IMG_W_MAX; i++) begin
                lb0_q[i] <= '0;
                lb1_q[i] <= '0;
            end
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            w_q <= w_d; h_q <= h_d; relu_q <= relu_d; shift_q <= shift_d;
            col_q <= col_d; row_q <= row_d;
            out_valid_q <= out_valid_d; out_last_q <= out_last_d; out_data_q <= out_data_d;
            wt_q <= wt_d; lb0_q <= lb0_d; lb1_q <= lb1_d; win_q <= win_d;
            case (state_q)
                IDLE: if (start_i) begin
                    err_q   <= dims_bad;
                    state_q <= dims_bad ? DONE : RUN;
                end
                RUN:   if (pix_fire && last_pix) state_q <= DRAIN;
                DRAIN: if (out_fire && out_last_q) state_q <= DONE;
                DONE:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
